// File: rtl/fpm_pkg.sv
// Shared constants, operand payload type and helpers for the FP multiplier slice.
package fpm_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Operand pair presented to the multiplier datapath
    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } fpm_operands_t;

    // Ceiling log2 for elaboration-time width calculations
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fpm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
module fpm_rr_arbiter
    import fpm_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_any
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] cand;

    // Scan requesters starting one past the pointer, wrapping at N_REQ-1
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (en) begin
            for (int unsigned off = 1; off <= N_REQ; off++) begin
                cand = IDW'((32'(ptr_q) + off) % N_REQ);
                if (!grant_any && req[cand]) begin
                    grant[cand] = 1'b1;
                    grant_idx   = cand;
                    grant_any   = 1'b1;
                end
            end
        end
    end

    // Pointer follows the winner; idle cycles leave it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDW'(N_REQ - 1);
        end else if (grant_any) begin
            ptr_q <= grant_idx;
        end
    end

endmodule

// File: rtl/fpm_issue_arbiter.sv
// Shares one pipelined FP multiplier among N_REQ requesters, tagging each op with its ID.
module fpm_issue_arbiter
    import fpm_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LAT   = 3,
    parameter int unsigned IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [FP_W*N_REQ-1:0]   req_a,
    input  logic [FP_W*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    flush,
    output logic                    mul_en,
    output logic [FP_W-1:0]         mul_a,
    output logic [FP_W-1:0]         mul_b,
    input  logic [FP_W-1:0]         mul_c,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [FP_W-1:0]         rsp_c,
    output logic [clog2(LAT+1):0]   inflight
);

    localparam int unsigned CNT_W = clog2(LAT + 1) + 1;

    logic             issue_en;
    logic             issue;
    logic             retire;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_idx;
    fpm_operands_t    ops;

    logic [LAT-1:0]   vld_q;
    logic [IDW-1:0]   id_q [LAT];

    // Consumer backpressure freezes the whole multiplier pipe
    assign mul_en   = !(rsp_valid && !rsp_ready);
    // Reset and flush both suppress acceptance in the same cycle
    assign issue_en = rst_n && mul_en && !flush;
    assign retire   = rsp_valid && rsp_ready;

    fpm_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .en        (issue_en),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (issue)
    );

    assign req_ready = grant;

    // Operand mux driven by the one-hot grant; zero when nothing is granted
    always_comb begin
        ops = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                ops.a = req_a[FP_W*i +: FP_W];
                ops.b = req_b[FP_W*i +: FP_W];
            end
        end
    end

    assign mul_a = ops.a;
    assign mul_b = ops.b;

    // Tag pipe mirrors the multiplier stages; flush only clears valids, data is masked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            if (mul_en) begin
                id_q[0] <= grant_idx;
                for (int unsigned k = 1; k < LAT; k++) begin
                    id_q[k] <= id_q[k-1];
                end
            end
            if (flush) begin
                vld_q <= '0;
            end else if (mul_en) begin
                vld_q[0] <= issue;
                for (int unsigned k = 1; k < LAT; k++) begin
                    vld_q[k] <= vld_q[k-1];
                end
            end
        end
    end

    assign rsp_valid = vld_q[LAT-1];
    assign rsp_id    = id_q[LAT-1];
    assign rsp_c     = mul_c;

    // Occupancy: issue adds, handshake retires, flush empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (flush) begin
            inflight <= '0;
        end else if (issue && !retire) begin
            inflight <= inflight + CNT_W'(1);
        end else if (!issue && retire) begin
            inflight <= inflight - CNT_W'(1);
        end
    end

endmodule
